// File: rtl/key_event_queue.sv
// Key-press event queue: serialises debounced 3x3 key pulses into 4-bit codes held in a FWFT FIFO.
// Optional KEY_EVT_TIMESTAMP_EN adds a 16-bit free-running timestamp stored alongside each code.
module key_event_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLOCK_50,
    input  logic             RST,
    input  logic [8:0]       key_flags,
    output logic             evt_valid,
    output logic [3:0]       evt_code,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    input  logic             clr_overflow
`ifdef KEY_EVT_TIMESTAMP_EN
    ,
    output logic [15:0]      evt_time
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [8:0]       pending_q, pending_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [3:0]       mem_q [DEPTH];

    logic [3:0]       grantIdx;
    logic [8:0]       grant;
    logic             push;
    logic             pop;
    logic             mergeHit;

`ifdef KEY_EVT_TIMESTAMP_EN
    logic [15:0]      time_q;
    logic [15:0]      tmem_q [DEPTH];
`endif

    // Scanning downward leaves the lowest set pending bit as the winner.
    always_comb begin
        grantIdx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (pending_q[i]) begin
                grantIdx = 4'(i);
            end
        end
    end

    always_comb begin
        pop        = (count_q != '0) && evt_ready;
        push       = (pending_q != '0) && ((count_q != CNT_W'(DEPTH)) || pop);
        grant      = push ? (9'd1 << grantIdx) : 9'd0;
        pending_d  = (pending_q & ~grant) | key_flags;
        mergeHit   = |(key_flags & pending_q & ~grant);

        overflow_d = overflow_q;
        if (mergeHit) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end

        head_d = pop  ? head_q + AW'(1) : head_q;
        tail_d = push ? tail_q + AW'(1) : tail_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            pending_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 4'd0;
            end
        end else if (push) begin
            mem_q[tail_q] <= grantIdx;
        end
    end

`ifdef KEY_EVT_TIMESTAMP_EN
    // Each entry captures the counter value seen at its push edge.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            time_q <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                tmem_q[i] <= 16'd0;
            end
        end else begin
            time_q <= time_q + 16'd1;
            if (push) begin
                tmem_q[tail_q] <= time_q;
            end
        end
    end

    assign evt_time = (count_q != '0) ? tmem_q[head_q] : 16'd0;
`endif

    assign evt_valid = (count_q != '0);
    assign evt_code  = evt_valid ? mem_q[head_q] : 4'd0;
    assign evt_count = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Randomised and directed bench for key_event_queue against a queue-based reference model.
// Timestamp checks are compiled in when KEY_EVT_TIMESTAMP_EN is defined.
module tb_key_event_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             CLOCK_50;
    logic             RST;
    logic [8:0]       key_flags;
    logic             evt_valid;
    logic [3:0]       evt_code;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;
    logic             clr_overflow;
`ifdef KEY_EVT_TIMESTAMP_EN
    logic [15:0]      evt_time;
`endif

    int checks;
    int failures;

    // Reference model: pending key set, FIFO as a queue, sticky overflow flag.
    bit [8:0] modelPending;
    int       modelFifo[$];
    bit       modelOverflow;
`ifdef KEY_EVT_TIMESTAMP_EN
    int       modelTimes[$];
    int       modelClock;
    int       firstTime;
`endif

    key_event_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLOCK_50     (CLOCK_50),
        .RST          (RST),
        .key_flags    (key_flags),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_ready    (evt_ready),
        .evt_count    (evt_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
`ifdef KEY_EVT_TIMESTAMP_EN
        ,
        .evt_time     (evt_time)
`endif
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelPending  = '0;
        modelFifo.delete();
        modelOverflow = 1'b0;
`ifdef KEY_EVT_TIMESTAMP_EN
        modelTimes.delete();
        modelClock = 0;
`endif
    endtask

    // One clock edge of the reference model, from the inputs presented before the edge.
    task automatic modelStep(input bit [8:0] flags, input bit ready, input bit clr);
        bit       doPop;
        bit       doPush;
        bit [8:0] grantMask;
        int       idx;
        doPop     = (modelFifo.size() > 0) && ready;
        doPush    = (modelPending != 0) && ((modelFifo.size() < DEPTH) || doPop);
        grantMask = '0;
        if (doPop) begin
            void'(modelFifo.pop_front());
`ifdef KEY_EVT_TIMESTAMP_EN
            void'(modelTimes.pop_front());
`endif
        end
        if (doPush) begin
            idx = 0;
            while (!modelPending[idx]) idx++;
            modelFifo.push_back(idx);
            grantMask[idx] = 1'b1;
`ifdef KEY_EVT_TIMESTAMP_EN
            modelTimes.push_back(modelClock);
`endif
        end
        if ((flags & modelPending & ~grantMask) != 0) begin
            modelOverflow = 1'b1;
        end else if (clr) begin
            modelOverflow = 1'b0;
        end
        modelPending = (modelPending & ~grantMask) | flags;
`ifdef KEY_EVT_TIMESTAMP_EN
        modelClock = (modelClock + 1) % 65536;
`endif
    endtask

    task automatic compareAll(input string phase);
        checkOutput({phase, ".count"}, int'(evt_count), modelFifo.size());
        checkOutput({phase, ".valid"}, int'(evt_valid), int'(modelFifo.size() != 0));
        checkOutput({phase, ".code"}, int'(evt_code), (modelFifo.size() != 0) ? modelFifo[0] : 0);
        checkOutput({phase, ".overflow"}, int'(overflow), int'(modelOverflow));
`ifdef KEY_EVT_TIMESTAMP_EN
        checkOutput({phase, ".time"}, int'(evt_time), (modelTimes.size() != 0) ? modelTimes[0] : 0);
`endif
    endtask

    // Drive one cycle of inputs, advance DUT and model one edge, compare 1 time unit after the edge.
    task automatic applyStimulus(input string phase, input bit [8:0] flags, input bit ready, input bit clr);
        key_flags    = flags;
        evt_ready    = ready;
        clr_overflow = clr;
        modelStep(flags, ready, clr);
        @(posedge CLOCK_50);
        #1;
        compareAll(phase);
    endtask

    initial begin
        bit [8:0] rndFlags;
        checks       = 0;
        failures     = 0;
        key_flags    = '0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        RST          = 1'b0;
        modelReset();

        #2 RST = 1'b1;
        #1;
        compareAll("reset");
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RST = 1'b0;

        for (int i = 0; i < 20; i++) applyStimulus("idle", 9'd0, 1'b1, 1'b0);

        $display("[TB] single key 4, two-cycle latency");
        applyStimulus("single.pulse", 9'b000010000, 1'b0, 1'b0);
        checkOutput("single.notYetValid", int'(evt_valid), 0);
        applyStimulus("single.wait", 9'd0, 1'b0, 1'b0);
        checkOutput("single.code4", int'(evt_code), 4);
        applyStimulus("single.hold", 9'd0, 1'b0, 1'b0);
        applyStimulus("single.pop", 9'd0, 1'b1, 1'b0);
        checkOutput("single.empty", int'(evt_count), 0);

        $display("[TB] simultaneous keys 0,2,8");
        applyStimulus("multi.pulse", 9'b100000101, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus("multi.fill", 9'd0, 1'b0, 1'b0);
        checkOutput("multi.count3", int'(evt_count), 3);
        for (int i = 0; i < 4; i++) applyStimulus("multi.drain", 9'd0, 1'b1, 1'b0);

        $display("[TB] fill to DEPTH with ten pulses");
        for (int k = 0; k < 10; k++) begin
            rndFlags = 9'd1 << ((k == 9) ? 0 : k);
            applyStimulus("full.pulse", rndFlags, 1'b0, 1'b0);
            applyStimulus("full.gap", 9'd0, 1'b0, 1'b0);
            applyStimulus("full.gap", 9'd0, 1'b0, 1'b0);
        end
        checkOutput("full.count8", int'(evt_count), 8);
        checkOutput("full.noOverflow", int'(overflow), 0);

        $display("[TB] overflow set, clear, and set-wins");
        applyStimulus("ovf.first", 9'b000001000, 1'b0, 1'b0);
        applyStimulus("ovf.second", 9'b000001000, 1'b0, 1'b0);
        checkOutput("ovf.set", int'(overflow), 1);
        applyStimulus("ovf.clear", 9'd0, 1'b0, 1'b1);
        checkOutput("ovf.cleared", int'(overflow), 0);
        applyStimulus("ovf.both", 9'b000001000, 1'b0, 1'b1);
        checkOutput("ovf.setWins", int'(overflow), 1);
        applyStimulus("ovf.clear2", 9'd0, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) applyStimulus("ovf.drain", 9'd0, 1'b1, 1'b0);
        checkOutput("ovf.drained", int'(evt_count), 0);

`ifdef KEY_EVT_TIMESTAMP_EN
        $display("[TB] timestamp spacing");
        applyStimulus("ts.first", 9'b000000010, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus("ts.gap", 9'd0, 1'b0, 1'b0);
        firstTime = int'(evt_time);
        applyStimulus("ts.second", 9'b000000100, 1'b0, 1'b0);
        applyStimulus("ts.wait", 9'd0, 1'b0, 1'b0);
        applyStimulus("ts.pop", 9'd0, 1'b1, 1'b0);
        checkOutput("ts.delta10", int'(evt_time) - firstTime, 10);
        applyStimulus("ts.pop2", 9'd0, 1'b1, 1'b0);
`endif

        $display("[TB] randomised traffic");
        for (int i = 0; i < 2000; i++) begin
            rndFlags = '0;
            for (int b = 0; b < 9; b++) rndFlags[b] = ($urandom_range(0, 7) == 0);
            applyStimulus("rand", rndFlags, ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
        end

        $display("[TB] asynchronous reset with five queued");
        for (int i = 0; i < 12; i++) applyStimulus("prep.drain", 9'd0, 1'b1, 1'b1);
        applyStimulus("prep.pulse", 9'b000011111, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus("prep.fill", 9'd0, 1'b0, 1'b0);
        checkOutput("prep.count5", int'(evt_count), 5);
        #2 RST = 1'b1;
        #1;
        modelReset();
        checkOutput("async.count", int'(evt_count), 0);
        checkOutput("async.valid", int'(evt_valid), 0);
        compareAll("async");
        #1 RST = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus("post", 9'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
